reg_pipeline: RTL and testbench

REG_PIPELINE -- requirements
Module: reg_pipeline

---
 rtl/reg_pipeline.sv | 129 ++++++++++++
 tb/tb_reg_pipeline.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipeline.sv
// reg_pipeline: DEPTH-stage valid/ready register pipeline with bubble collapsing.
//
// Every stage holds one data word plus a valid bit. A stage accepts new
// content whenever it is empty or the stage below it is accepting, so holes
// in the pipeline fill up even while the consumer is stalling. With a
// continuous stream and no back-pressure, one item passes per clock.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//   RESET  value loaded into every data stage on rst or clr
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear; empties the pipeline, dominates transfers
//   in_valid   in_data is offered
//   in_data    data offered to stage 0
//   in_ready   stage 0 can accept this cycle (forced low while clr is high)
//   out_valid  last stage holds a valid item
//   out_data   data of the last stage
//   out_ready  consumer accepts out_data this cycle
//   count      number of valid stages
//
// Build option
//   REG_PIPELINE_COUNT_EN  when defined, count is a registered occupancy
//                          counter; otherwise count is tied to zero and no
//                          counter logic exists.

module reg_pipeline #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] ready;

  // ready_k = ~valid_k | ready_(k+1), ready_DEPTH = out_ready.
  // Unrolled from the output side with a running OR so that no bit of the
  // ready vector is read back while it is being built.
  always_comb begin : ready_chain
    logic acc;
    acc   = out_ready;
    ready = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      acc                = acc | ~valid_q[DEPTH-1-i];
      ready[DEPTH-1-i]   = acc;
    end
  end

  assign in_ready  = ready[0] & ~clr;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Stage registers. Data only moves along with a valid item, so an empty
  // stage keeps whatever it last held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET;
      end
    end else if (clr) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET;
      end
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= in_data;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (ready[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

`ifdef REG_PIPELINE_COUNT_EN
  logic          push;
  logic          pop;
  logic [CW-1:0] count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Push and pop together leave the occupancy unchanged. Push can only
  // happen with a free slot (or a simultaneous pop), and pop only with an
  // item present, so the counter stays within 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !push) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign count = count_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
module tb_reg_pipeline;

  localparam int          W     = 4;
  localparam int          D     = 3;
  localparam logic [3:0]  RSTV  = 4'ha;

  logic       clk = 1'b0;
  bit         clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  reg_pipeline #(.WIDTH(W), .DEPTH(D), .RESET(RSTV)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference model: a FIFO of items, each tagged with its stage position.
  // An item moves one stage forward if the consumer is ready or there is a
  // free slot anywhere ahead of it; the oldest item leaves from the last
  // stage when the consumer is ready.
  int         q_pos[$];
  logic [3:0] q_dat[$];
  logic [3:0] m_last;

  task automatic model_reset();
    q_pos.delete();
    q_dat.delete();
    m_last = RSTV;
  endtask

  function automatic logic exp_ready();
    return !clr && (out_ready || q_pos.size() < D);
  endfunction

  function automatic logic exp_valid();
    return q_pos.size() > 0 && q_pos[0] == D - 1;
  endfunction

  function automatic logic [1:0] exp_count();
`ifdef REG_PIPELINE_COUNT_EN
    return 2'(q_pos.size());
`else
    return 2'd0;
`endif
  endfunction

  task automatic model_edge();
    bit push, pop;
    if (clr) begin
      model_reset();
    end else begin
      push = in_valid && (out_ready || q_pos.size() < D);
      pop  = exp_valid() && out_ready;
      for (int i = 0; i < q_pos.size(); i++) begin
        if (q_pos[i] < D - 1 && (out_ready || i < D - 1 - q_pos[i])) begin
          q_pos[i] = q_pos[i] + 1;
          if (q_pos[i] == D - 1) m_last = q_dat[i];
        end
      end
      if (pop) begin
        void'(q_pos.pop_front());
        void'(q_dat.pop_front());
      end
      if (push) begin
        q_pos.push_back(0);
        q_dat.push_back(in_data);
        if (D == 1) m_last = in_data;
      end
    end
  endtask

  task automatic drive(input bit iv, input logic [3:0] d, input bit ordy, input bit c);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_data !== RSTV) begin n_fail++; $display("FAIL rst_data got=%h exp=%h", out_data, RSTV); end
    n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_latency();
    logic [3:0] dv [6] = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 4'h0};
    bit         iv [6] = '{1, 1, 1, 0, 0, 0};
    logic [3:0] ex [6] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
    for (int c = 0; c < 6; c++) begin
      drive(iv[c], dv[c], 1'b1, 1'b0);
      n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL lat_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready()); end
      step();
      n_tests++; if (out_valid !== (ex[c] != 4'h0)) begin n_fail++; $display("FAIL lat_valid c=%0d got=%b exp=%b", c, out_valid, ex[c] != 4'h0); end
      if (ex[c] != 4'h0) begin
        n_tests++; if (out_data !== ex[c]) begin n_fail++; $display("FAIL lat_data c=%0d got=%h exp=%h", c, out_data, ex[c]); end
      end
      n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL lat_model_data c=%0d got=%h exp=%h", c, out_data, m_last); end
      n_tests++; if (count !== exp_count()) begin n_fail++; $display("FAIL lat_count c=%0d got=%0d exp=%0d", c, count, exp_count()); end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'($urandom), 1'b0, 1'b0);
      n_tests++; if (in_ready !== (c < 3)) begin n_fail++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, c < 3); end
      step();
`ifdef REG_PIPELINE_COUNT_EN
      n_tests++; if (count !== 2'((c < 3) ? c + 1 : 3)) begin n_fail++; $display("FAIL bp_count c=%0d got=%0d exp=%0d", c, count, (c < 3) ? c + 1 : 3); end
`endif
      n_tests++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid()); end
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'($urandom), 1'b1, 1'b0);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      step();
`ifdef REG_PIPELINE_COUNT_EN
      n_tests++; if (count !== 2'd3) begin n_fail++; $display("FAIL b2b_count c=%0d got=%0d exp=3", c, count); end
`endif
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, out_valid); end
      n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, out_data, m_last); end
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      step();
      n_tests++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL drain_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid()); end
      n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL drain_data c=%0d got=%h exp=%h", c, out_data, m_last); end
    end
  endtask

  task automatic test_bubble();
    bit         iv [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    logic [3:0] dv [8] = '{4'h5, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    bit         ordy [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    for (int c = 0; c < 8; c++) begin
      drive(iv[c], dv[c], ordy[c], 1'b0);
      step();
      n_tests++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL bub_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid()); end
      n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL bub_data c=%0d got=%h exp=%h", c, out_data, m_last); end
      n_tests++; if (count !== exp_count()) begin n_fail++; $display("FAIL bub_count c=%0d got=%0d exp=%0d", c, count, exp_count()); end
      if (c == 4) begin
`ifdef REG_PIPELINE_COUNT_EN
        n_tests++; if (count !== 2'd2) begin n_fail++; $display("FAIL bub_held_count got=%0d exp=2", count); end
`endif
        n_tests++; if (out_data !== 4'h5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bub_first got=%b/%h exp=1/5", out_valid, out_data); end
      end
      if (c == 5) begin
        n_tests++; if (out_data !== 4'h6 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bub_second got=%b/%h exp=1/6", out_valid, out_data); end
      end
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 4'h7, 1'b0, 1'b0); step();
    drive(1'b1, 4'h8, 1'b0, 1'b0); step();
    drive(1'b1, 4'h9, 1'b0, 1'b1);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got=%b exp=0", in_ready); end
    step();
    n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL clr_count got=%0d exp=0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_data !== RSTV) begin n_fail++; $display("FAIL clr_data got=%h exp=%h", out_data, RSTV); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0); step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_after_valid c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_random();
    bit iv, ordy, c;
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom % 4) != 0;
      ordy = (n < 130) ? ($urandom % 2) : (n < 260) ? (($urandom % 5) == 0) : (($urandom % 5) != 0);
      c    = ($urandom % 30) == 0;
      drive(iv, 4'($urandom), ordy, c);
      n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_ready()); end
      step();
      n_tests++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, exp_valid()); end
      n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, out_data, m_last); end
      n_tests++; if (count !== exp_count()) begin n_fail++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, exp_count()); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    repeat (4) step();
    drive(1'b1, 4'hb, 1'b0, 1'b0); step();
    drive(1'b1, 4'hc, 1'b0, 1'b0); step();
    drive(1'b1, 4'hd, 1'b0, 1'b0); step();
    drive(1'b1, 4'he, 1'b0, 1'b0);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_data !== RSTV) begin n_fail++; $display("FAIL arst_data got=%h exp=%h", out_data, RSTV); end
    n_tests++; if (count !== 2'd0) begin n_fail++; $display("FAIL arst_count got=%0d exp=0", count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0); step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale c=%0d got=%b exp=0", c, out_valid); end
    end
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 4'h3, 1'b1, 1'b0); step();
      n_tests++; if (out_valid !== (c == 2)) begin n_fail++; $display("FAIL arst_resume_valid c=%0d got=%b exp=%b", c, out_valid, c == 2); end
      n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL arst_resume_data c=%0d got=%h exp=%h", c, out_data, m_last); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_bubble();
    test_clear();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
